// File: rtl/irq_dispatch_master.sv
// Second Wishbone initiator that services the interrupt controller: reads IRQ0_STATUS, masks the
// lowest pending source, hands its vector to a consumer, and re-enables it after end-of-interrupt.
module irq_dispatch_master #(
   parameter int          WB_DWIDTH  = 32,
   parameter int          WB_SWIDTH  = WB_DWIDTH / 8,
   parameter logic [31:0] IC_BASE    = 32'h1400_0000,
   parameter logic [15:0] STATUS_OFF = 16'h0000,
   parameter logic [15:0] ENSET_OFF  = 16'h0008,
   parameter logic [15:0] ENCLR_OFF  = 16'h000C,
   parameter int          TIMEOUT    = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_irq,
   output logic [31:0]          o_wb_adr,
   output logic [WB_SWIDTH-1:0] o_wb_sel,
   output logic                 o_wb_we,
   output logic [WB_DWIDTH-1:0] o_wb_dat,
   input  logic [WB_DWIDTH-1:0] i_wb_dat,
   output logic                 o_wb_cyc,
   output logic                 o_wb_stb,
   input  logic                 i_wb_ack,
   input  logic                 i_wb_err,
   output logic                 o_vec_valid,
   output logic [4:0]           o_vec,
   input  logic                 i_vec_ready,
   input  logic                 i_eoi,
   output logic                 o_busy,
   output logic                 o_err
);

   localparam int          NLANES     = WB_DWIDTH / 32;
   localparam logic [31:0] ADR_STATUS = IC_BASE | {16'h0000, STATUS_OFF};
   localparam logic [31:0] ADR_ENSET  = IC_BASE | {16'h0000, ENSET_OFF};
   localparam logic [31:0] ADR_ENCLR  = IC_BASE | {16'h0000, ENCLR_OFF};
   localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_STAT,
      S_MASK,
      S_PRESENT,
      S_WAIT_EOI,
      S_UNMASK
   } state_t;

   state_t                 state_q, state_d;
   logic                   cyc_q, cyc_d;
   logic                   stb_q, stb_d;
   logic                   we_q, we_d;
   logic [31:0]            adr_q, adr_d;
   logic [WB_DWIDTH-1:0]   dat_q, dat_d;
   logic [WB_SWIDTH-1:0]   sel_q, sel_d;
   logic                   vec_valid_q, vec_valid_d;
   logic [4:0]             vec_q, vec_d;
   logic                   err_q, err_d;
   logic [7:0]             tmo_q, tmo_d;

   logic [31:0]            rd_word;
   logic [4:0]             low_idx;
   logic                   bus_state;
   logic                   bus_abort;
   logic                   bus_start;
   logic                   bus_we;
   logic [31:0]            bus_adr;
   logic [31:0]            bus_word;

   // Read data comes from the 32-bit lane addressed by adr[3:2] on wide buses.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NLANES; i++) begin
         if (NLANES == 1 || 2'(i) == adr_q[3:2]) begin
            rd_word = i_wb_dat[32*i +: 32];
         end
      end
   end

   // Scan downwards so the lowest set bit is the last one to win.
   always_comb begin
      low_idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (rd_word[i]) begin
            low_idx = 5'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      vec_valid_d = vec_valid_q;
      vec_d       = vec_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      bus_start   = 1'b0;
      bus_we      = 1'b0;
      bus_adr     = '0;
      bus_word    = '0;

      bus_state = (state_q == S_RD_STAT) || (state_q == S_MASK) || (state_q == S_UNMASK);
      // Error beats ack; the timeout fires on the TIMEOUT-th strobed cycle without a response.
      bus_abort = bus_state && (i_wb_err || (!i_wb_ack && tmo_q == TMO_LAST));

      if (bus_abort) begin
         state_d = S_IDLE;
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         we_d    = 1'b0;
         err_d   = 1'b1;
      end else begin
         if (bus_state && !i_wb_ack) begin
            tmo_d = tmo_q + 8'd1;
         end
         if (bus_state && i_wb_ack) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (i_irq) begin
                  state_d   = S_RD_STAT;
                  bus_start = 1'b1;
                  bus_adr   = ADR_STATUS;
               end
            end
            S_RD_STAT: begin
               if (i_wb_ack) begin
                  if (rd_word == 32'h0) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d   = S_MASK;
                     vec_d     = low_idx;
                     bus_start = 1'b1;
                     bus_we    = 1'b1;
                     bus_adr   = ADR_ENCLR;
                     bus_word  = 32'h1 << low_idx;
                  end
               end
            end
            S_MASK: begin
               if (i_wb_ack) begin
                  state_d     = S_PRESENT;
                  vec_valid_d = 1'b1;
               end
            end
            S_PRESENT: begin
               if (i_vec_ready) begin
                  state_d     = S_WAIT_EOI;
                  vec_valid_d = 1'b0;
               end
            end
            S_WAIT_EOI: begin
               if (i_eoi) begin
                  state_d   = S_UNMASK;
                  bus_start = 1'b1;
                  bus_we    = 1'b1;
                  bus_adr   = ADR_ENSET;
                  bus_word  = 32'h1 << vec_q;
               end
            end
            S_UNMASK: begin
               if (i_wb_ack) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // A new transfer replicates the word on every lane and enables only the addressed one.
      if (bus_start) begin
         cyc_d = 1'b1;
         stb_d = 1'b1;
         we_d  = bus_we;
         adr_d = bus_adr;
         tmo_d = '0;
         for (int i = 0; i < NLANES; i++) begin
            dat_d[32*i +: 32] = bus_word;
            sel_d[4*i +: 4]   = (NLANES == 1 || 2'(i) == bus_adr[3:2]) ? 4'hF : 4'h0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         vec_valid_q <= 1'b0;
         vec_q       <= '0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         vec_valid_q <= vec_valid_d;
         vec_q       <= vec_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
      end
   end

   assign o_wb_cyc    = cyc_q;
   assign o_wb_stb    = stb_q;
   assign o_wb_we     = we_q;
   assign o_wb_adr    = adr_q;
   assign o_wb_dat    = dat_q;
   assign o_wb_sel    = sel_q;
   assign o_vec_valid = vec_valid_q;
   assign o_vec       = vec_q;
   assign o_err       = err_q;
   assign o_busy      = (state_q != S_IDLE);

endmodule
